frame_scanout: RTL and testbench
================================

Name: frame_scanout

Overview:
- Parametrised successor to the current frame displayer: a scaled, double-buffered, palette-driven scanout engine between the VGA controller and the frame buffer.
- Converts DrawX/DrawY into frame-buffer read addresses with 1x/2x/4x pixel replication, then maps returned pixel codes to 24-bit RGB through a writable palette or fixed RGB332 expansion.
- Delays hs/vs/blank to match the colour pipeline, and swaps front/back buffers only at frame start through a req/ack handshake.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines
- PIX_W, 8, pixel code width in the frame buffer
- ADDR_W, 19, frame-buffer address width
- SCALE_LOG2, 0, replication factor 2^SCALE_LOG2; legal values 0..2
- RD_LATENCY, 1, frame-buffer read latency in pixel_en beats; legal values 1..4
- BUF1_BASE, 19'h4B000, base address of buffer 1 (buffer 0 base is 0)
- PAL_EN, 1, 1 = palette lookup; 0 = fixed RGB332 expansion (requires PIX_W=8)

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset_n  in  1  asynchronous active-low reset
- pixel_en  in  1  one-Clk strobe per pixel, synchronous to the VGA pixel clock
- DrawX  in  10  current pixel column from vga_controller
- DrawY  in  10  current pixel row from vga_controller
- hs_in, vs_in, blank_in  in  1 each  raw syncs from vga_controller (blank_in active low)
- frame_rdAddress  out  ADDR_W  frame-buffer read address
- frame_output  in  PIX_W  frame-buffer read data
- pal_we  in  1  palette write strobe
- pal_addr  in  PIX_W  palette write index
- pal_data  in  24  palette entry, {R,G,B}
- swap_req  in  1  level request to swap front buffer
- swap_ack  out  1  one-Clk pulse when the swap has been applied
- front_sel  out  1  buffer currently scanned
- Red, Green, Blue  out  8 each  colour outputs
- hs_out, vs_out, blank_out  out  1 each  syncs aligned to colour outputs

Behaviour:
- All pipeline registers advance only on Clk cycles with pixel_en=1. The palette write port and the swap FSM run every Clk.
- Reset values: frame_rdAddress=0, Red/Green/Blue=0, hs_out=1, vs_out=1, blank_out=0, swap_ack=0, front_sel=0, FSM=IDLE, all delay lines flushed to these idle values.
- Palette RAM contents are not cleared by reset.
- Stage A (address): active = (DrawX<H_RES && DrawY<V_RES).
  - If active: frame_rdAddress = base + (DrawY>>S)*(H_RES>>S) + (DrawX>>S), truncated to ADDR_W. base = 0 when front_sel=0, BUF1_BASE when front_sel=1.
  - If inactive: frame_rdAddress holds its previous value.
- frame_output is sampled RD_LATENCY beats after Stage A.
- Stage C (colour):
  - PAL_EN=1: RGB = palette[code].
  - PAL_EN=0: R = {c[7:5],c[7:5],c[7:6]}, G = {c[4:2],c[4:2],c[4:3]}, B = {c[1:0],c[1:0],c[1:0],c[1:0]}.
  - Inactive pixels output RGB=0.
- Total latency from DrawX/DrawY sampling to colour output is RD_LATENCY+2 pixel_en beats. hs/vs/blank pass through a delay line of the same length.
- Palette write/read collision on the same index in the same Clk: the read returns the old entry; the write completes.
- Frame start = pixel_en && DrawX==0 && DrawY==0.
- Swap FSM:
  - IDLE -> PENDING when swap_req=1.
  - PENDING -> ACK at frame start: front_sel toggles in that same Clk, before Stage A uses it, so pixel (0,0) already reads the new buffer.
  - ACK: swap_ack=1 for exactly one Clk, then WAIT_LOW.
  - WAIT_LOW -> IDLE when swap_req=0. This gives one swap per request edge.
  - swap_req deasserted while PENDING: return to IDLE with no swap.
- front_sel never changes mid-frame.
- Reset mid-frame: outputs return to reset values immediately. Scanout resumes with buffer 0 on the next pixel_en; any pending swap is lost.
- SCALE_LOG2 is ignored on out-of-range values (treated as 0); H_RES and V_RES must be divisible by 2^SCALE_LOG2.

Test Plan:
- Reset_n low mid-line -> RGB=0, hs_out=1, blank_out=0, front_sel=0, swap_ack=0 within the same cycle. Release, pixel_en every 2nd Clk, DrawX=5/DrawY=2, S=0 -> frame_rdAddress=1285 one beat later.
- S=1, DrawX=639/DrawY=479 -> frame_rdAddress=239*320+319=76799. S=2, same DrawX/DrawY -> frame_rdAddress=119*160+159=19199.
- Palette: write idx 8'h2A = 24'h12_34_56, feed frame_output=8'h2A -> Red=8'h12, Green=8'h34, Blue=8'h56 exactly RD_LATENCY+2 beats after Stage A. hs_in pulse emerges on hs_out in the same beat.
- Swap: swap_req at mid-frame -> swap_ack pulse coincides with DrawX=0/DrawY=0. First address is BUF1_BASE=19'h4B000. Holding swap_req high produces no second swap.
- Blanking: DrawX=700 -> RGB=0 and frame_rdAddress unchanged. PAL_EN=0, code 8'hE0 -> Red=8'hFF, Green=0, Blue=0.

Source files
------------

// File: rtl/frame_scanout.sv
// frame_scanout: scaled, double-buffered, palette-driven scanout between vga_controller and the frame buffer.
// Latency: RD_LATENCY+2 pixel_en beats from DrawX/DrawY to colour; hs/vs/blank are delayed by the same amount.
// Backpressure: none; the pipeline advances on pixel_en only, while the palette write port and swap FSM run every Clk.
//
// Ports:
//   Clk, Reset_n                 clock, async active-low reset
//   pixel_en                     one-Clk strobe per pixel
//   DrawX, DrawY                 current pixel position
//   hs_in, vs_in, blank_in       raw syncs (blank_in active low)
//   frame_rdAddress/frame_output frame-buffer read address / returned pixel code
//   pal_we, pal_addr, pal_data   palette write port, {R,G,B}
//   swap_req/swap_ack/front_sel  front-buffer swap handshake and current buffer
//   Red, Green, Blue             colour outputs
//   hs_out, vs_out, blank_out    syncs aligned to the colour outputs
module frame_scanout #(
  parameter int unsigned       H_RES      = 640,
  parameter int unsigned       V_RES      = 480,
  parameter int unsigned       PIX_W      = 8,
  parameter int unsigned       ADDR_W     = 19,
  parameter int unsigned       SCALE_LOG2 = 0,
  parameter int unsigned       RD_LATENCY = 1,
  parameter logic [ADDR_W-1:0] BUF1_BASE  = 19'h4B000,
  parameter bit                PAL_EN     = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pixel_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_in,
  output logic [ADDR_W-1:0] frame_rdAddress,
  input  logic [PIX_W-1:0]  frame_output,
  input  logic              pal_we,
  input  logic [PIX_W-1:0]  pal_addr,
  input  logic [23:0]       pal_data,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_sel,
  output logic [7:0]        Red,
  output logic [7:0]        Green,
  output logic [7:0]        Blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_out
);

  // Out-of-range scale factors fall back to 1x replication.
  localparam int unsigned S      = (SCALE_LOG2 <= 2) ? SCALE_LOG2 : 0;
  localparam int unsigned LINE_W = H_RES >> S;
  // Sideband entries: address stage, RD_LATENCY fetch beats, palette stage.
  localparam int unsigned DEPTH  = RD_LATENCY + 2;

  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
    logic blank;
  } sb_t;

  localparam sb_t SB_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1, blank: 1'b0};

  typedef enum logic [1:0] {IDLE, PENDING, ACK, WAIT_LOW} swap_state_t;

  swap_state_t      state_q, state_d;
  logic             frame_start;
  logic             do_swap;
  logic             sel_eff;
  logic             active;
  logic [31:0]      addr_full;
  logic [PIX_W-1:0] code_q;
  logic [23:0]      colour_q;
  sb_t              sb_line [DEPTH];

  // ---------------- swap FSM ----------------
  assign frame_start = pixel_en && (DrawX == 10'd0) && (DrawY == 10'd0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      front_sel <= 1'b0;
    end else begin
      state_q <= state_d;
      if (do_swap) front_sel <= ~front_sel;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_swap  = 1'b0;
    swap_ack = 1'b0;
    case (state_q)
      IDLE:     if (swap_req) state_d = PENDING;
      PENDING: begin
        // A withdrawn request is dropped without swapping.
        if (!swap_req) begin
          state_d = IDLE;
        end else if (frame_start) begin
          do_swap = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        swap_ack = 1'b1;
        state_d  = WAIT_LOW;
      end
      WAIT_LOW: if (!swap_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Pixel (0,0) must already address the new buffer, so stage A sees the
  // post-swap selection in the same Clk the swap is taken.
  assign sel_eff = front_sel ^ do_swap;

  // ---------------- stage A: address ----------------
  always_comb begin
    active    = (32'(DrawX) < H_RES) && (32'(DrawY) < V_RES);
    addr_full = (sel_eff ? 32'(BUF1_BASE) : 32'd0)
              + (32'(DrawY) >> S) * LINE_W
              + (32'(DrawX) >> S);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_rdAddress <= '0;
    end else if (pixel_en && active) begin
      frame_rdAddress <= addr_full[ADDR_W-1:0];
    end
  end

  // Sideband delay line; entry k holds the beat-0 sample after k more beats.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) sb_line[i] <= SB_IDLE;
    end else if (pixel_en) begin
      sb_line[0] <= '{active: active, hs: hs_in, vs: vs_in, blank: blank_in};
      for (int i = 1; i < int'(DEPTH); i++) sb_line[i] <= sb_line[i-1];
    end
  end

  // ---------------- fetch: frame buffer data ----------------
  // Captured every beat; the data of the pixel addressed RD_LATENCY beats
  // earlier is present on frame_output at this point.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      code_q <= '0;
    end else if (pixel_en) begin
      code_q <= frame_output;
    end
  end

  // ---------------- colour lookup ----------------
  generate
    if (PAL_EN) begin : g_pal
      logic [23:0] pal_mem [2**PIX_W];

      // Not reset; a same-Clk read of the written index sees the old entry.
      always_ff @(posedge Clk) begin
        if (pal_we) pal_mem[pal_addr] <= pal_data;
      end

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          colour_q <= '0;
        end else if (pixel_en) begin
          colour_q <= pal_mem[code_q];
        end
      end
    end else begin : g_rgb332
      logic unused_pal;
      assign unused_pal = ^{pal_we, pal_addr, pal_data};

      // RGB332 expanded by bit replication so full-scale codes reach 8'hFF.
      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          colour_q <= '0;
        end else if (pixel_en) begin
          colour_q <= {code_q[7:5], code_q[7:5], code_q[7:6],
                       code_q[4:2], code_q[4:2], code_q[4:3],
                       {4{code_q[1:0]}}};
        end
      end
    end
  endgenerate

  // ---------------- output stage ----------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= 8'd0;
      Green     <= 8'd0;
      Blue      <= 8'd0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      blank_out <= 1'b0;
    end else if (pixel_en) begin
      {Red, Green, Blue} <= sb_line[DEPTH-1].active ? colour_q : 24'd0;
      hs_out    <= sb_line[DEPTH-1].hs;
      vs_out    <= sb_line[DEPTH-1].vs;
      blank_out <= sb_line[DEPTH-1].blank;
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
// tb_frame_scanout: directed bench for frame_scanout (1x palette, 2x, 4x and RGB332 instances on shared inputs).
// Latency: each beat is two Clk cycles with pixel_en on the first; colour appears RD_LATENCY+2 beats after its address.
// Backpressure: none; stimulus is a fixed linear sequence.
module tb_frame_scanout;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        pixel_en;
  logic [9:0]  DrawX, DrawY;
  logic        hs_in, vs_in, blank_in;
  logic [7:0]  frame_output;
  logic        pal_we;
  logic [7:0]  pal_addr;
  logic [23:0] pal_data;
  logic        swap_req;
  logic        ack_mid;

  logic [18:0] a_addr, s1_addr, s2_addr, c_addr;
  logic        a_ack, s1_ack, s2_ack, c_ack;
  logic        a_sel, s1_sel, s2_sel, c_sel;
  logic [7:0]  a_r, a_g, a_b, s1_r, s1_g, s1_b, s2_r, s2_g, s2_b, c_r, c_g, c_b;
  logic        a_hs, a_vs, a_bl, s1_hs, s1_vs, s1_bl, s2_hs, s2_vs, s2_bl, c_hs, c_vs, c_bl;

  int n_checks = 0;
  int n_err    = 0;

  always #5 Clk = ~Clk;

  frame_scanout u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .frame_rdAddress(a_addr),
    .frame_output(frame_output), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .swap_req(swap_req), .swap_ack(a_ack), .front_sel(a_sel), .Red(a_r), .Green(a_g),
    .Blue(a_b), .hs_out(a_hs), .vs_out(a_vs), .blank_out(a_bl));

  frame_scanout #(.SCALE_LOG2(1)) u_s1 (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .frame_rdAddress(s1_addr),
    .frame_output(frame_output), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .swap_req(swap_req), .swap_ack(s1_ack), .front_sel(s1_sel), .Red(s1_r), .Green(s1_g),
    .Blue(s1_b), .hs_out(s1_hs), .vs_out(s1_vs), .blank_out(s1_bl));

  frame_scanout #(.SCALE_LOG2(2)) u_s2 (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .frame_rdAddress(s2_addr),
    .frame_output(frame_output), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .swap_req(swap_req), .swap_ack(s2_ack), .front_sel(s2_sel), .Red(s2_r), .Green(s2_g),
    .Blue(s2_b), .hs_out(s2_hs), .vs_out(s2_vs), .blank_out(s2_bl));

  frame_scanout #(.PAL_EN(1'b0)) u_332 (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en), .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in), .frame_rdAddress(c_addr),
    .frame_output(frame_output), .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .swap_req(swap_req), .swap_ack(c_ack), .front_sel(c_sel), .Red(c_r), .Green(c_g),
    .Blue(c_b), .hs_out(c_hs), .vs_out(c_vs), .blank_out(c_bl));

  // Outputs of the auxiliary instances that the sequence does not look at.
  wire unused_sink = ^{s1_ack, s1_sel, s1_r, s1_g, s1_b, s1_hs, s1_vs, s1_bl,
                       s2_ack, s2_sel, s2_r, s2_g, s2_b, s2_hs, s2_vs, s2_bl,
                       c_addr, c_ack, c_sel, c_hs, c_vs, c_bl};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel beat: pixel_en on the first Clk, idle second Clk; returns #1 after the second edge.
  // ack_mid captures swap_ack just after the pixel_en edge.
  task automatic beat(input logic [9:0] x, input logic [9:0] y, input logic h, input logic [7:0] fo);
    DrawX        = x;
    DrawY        = y;
    hs_in        = h;
    frame_output = fo;
    pixel_en     = 1'b1;
    @(posedge Clk);
    #1;
    pixel_en = 1'b0;
    pal_we   = 1'b0;
    ack_mid  = a_ack;
    @(posedge Clk);
    #1;
  endtask

  task automatic pal_write(input logic [7:0] idx, input logic [23:0] dat);
    pal_we   = 1'b1;
    pal_addr = idx;
    pal_data = dat;
    @(posedge Clk);
    #1;
    pal_we = 1'b0;
  endtask

  initial begin
    Reset_n      = 1'b1;
    pixel_en     = 1'b0;
    DrawX        = 10'd0;
    DrawY        = 10'd0;
    hs_in        = 1'b1;
    vs_in        = 1'b1;
    blank_in     = 1'b1;
    frame_output = 8'h00;
    pal_we       = 1'b0;
    pal_addr     = 8'h00;
    pal_data     = 24'h0;
    swap_req     = 1'b0;
    ack_mid      = 1'b0;

    // Reset state
    #2 Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_addr",  32'(a_addr), 32'd0);
    check("rst_red",   32'(a_r),    32'd0);
    check("rst_hs",    32'(a_hs),   32'd1);
    check("rst_vs",    32'(a_vs),   32'd1);
    check("rst_blank", 32'(a_bl),   32'd0);
    check("rst_ack",   32'(a_ack),  32'd0);
    check("rst_sel",   32'(a_sel),  32'd0);
    Reset_n = 1'b1;

    pal_write(8'h2A, 24'h123456);
    pal_write(8'h00, 24'h000000);

    // Address at 1x: 2*640+5
    beat(10'd5, 10'd2, 1'b1, 8'h00);
    check("addr_5_2", 32'(a_addr), 32'd1285);

    // Pipeline timing, hs alignment, palette collision
    beat(10'd10, 10'd0, 1'b0, 8'h00);                 // B0, hs pulse
    beat(10'd11, 10'd0, 1'b1, 8'h2A);                 // B1, code for B0
    pal_we = 1'b1; pal_addr = 8'h2A; pal_data = 24'hAABBCC;
    beat(10'd12, 10'd0, 1'b1, 8'h00);                 // B2, lookup of 2A collides with write
    check("pre_red",  32'(a_r),  32'h00);
    check("pre_hs",   32'(a_hs), 32'd1);
    beat(10'd13, 10'd0, 1'b1, 8'h00);                 // B3: B0 colour emerges
    check("pal_red",   32'(a_r),  32'h12);
    check("pal_green", 32'(a_g),  32'h34);
    check("pal_blue",  32'(a_b),  32'h56);
    check("pal_hs",    32'(a_hs), 32'd0);
    beat(10'd14, 10'd0, 1'b1, 8'h2A);                 // B4, code for B3
    check("post_red", 32'(a_r),  32'h00);
    check("post_hs",  32'(a_hs), 32'd1);
    beat(10'd15, 10'd0, 1'b1, 8'h00);
    beat(10'd16, 10'd0, 1'b1, 8'h00);                 // B6: B3 colour with new entry
    check("newpal_red",   32'(a_r), 32'hAA);
    check("newpal_green", 32'(a_g), 32'hBB);
    check("newpal_blue",  32'(a_b), 32'hCC);

    // Blanking: address held, colour forced to zero
    beat(10'd700, 10'd0, 1'b1, 8'h00);
    check("blank_addr_hold", 32'(a_addr), 32'd16);
    beat(10'd701, 10'd0, 1'b1, 8'h2A);
    beat(10'd702, 10'd0, 1'b1, 8'h2A);
    beat(10'd703, 10'd0, 1'b1, 8'h2A);
    check("blank_red",   32'(a_r), 32'h00);
    check("blank_green", 32'(a_g), 32'h00);
    check("blank_addr2", 32'(a_addr), 32'd16);

    // Scaled addressing at the last pixel
    beat(10'd639, 10'd479, 1'b1, 8'h00);
    check("addr_x1", 32'(a_addr),  32'd307199);
    check("addr_x2", 32'(s1_addr), 32'd76799);
    check("addr_x4", 32'(s2_addr), 32'd19199);

    // RGB332 expansion
    beat(10'd20, 10'd0, 1'b1, 8'h00);
    beat(10'd21, 10'd0, 1'b1, 8'hE0);
    beat(10'd22, 10'd0, 1'b1, 8'h1D);
    beat(10'd23, 10'd0, 1'b1, 8'h00);
    check("rgb332_E0_r", 32'(c_r), 32'hFF);
    check("rgb332_E0_g", 32'(c_g), 32'h00);
    check("rgb332_E0_b", 32'(c_b), 32'h00);
    beat(10'd24, 10'd0, 1'b1, 8'h00);
    check("rgb332_1D_r", 32'(c_r), 32'h00);
    check("rgb332_1D_g", 32'(c_g), 32'hFF);
    check("rgb332_1D_b", 32'(c_b), 32'h55);

    // Swap requested mid-frame, applied at frame start
    swap_req = 1'b1;
    beat(10'd100, 10'd10, 1'b1, 8'h00);
    beat(10'd101, 10'd10, 1'b1, 8'h00);
    check("swap_wait_ack", 32'(ack_mid), 32'd0);
    check("swap_wait_sel", 32'(a_sel),   32'd0);
    beat(10'd0, 10'd0, 1'b1, 8'h00);
    check("swap_ack_pulse", 32'(ack_mid), 32'd1);
    check("swap_ack_width", 32'(a_ack),   32'd0);
    check("swap_sel",       32'(a_sel),   32'd1);
    check("swap_addr00",    32'(a_addr),  32'h4B000);
    beat(10'd1, 10'd0, 1'b1, 8'h00);
    check("swap_addr10",    32'(a_addr),  32'h4B001);
    beat(10'd2, 10'd0, 1'b1, 8'h00);
    beat(10'd0, 10'd0, 1'b1, 8'h00);                  // held request: no second swap
    check("hold_no_ack", 32'(ack_mid), 32'd0);
    check("hold_sel",    32'(a_sel),   32'd1);
    check("hold_addr",   32'(a_addr),  32'h4B000);

    // Request withdrawn before frame start: no swap
    swap_req = 1'b0;
    beat(10'd50, 10'd5, 1'b1, 8'h00);
    swap_req = 1'b1;
    beat(10'd51, 10'd5, 1'b1, 8'h00);
    swap_req = 1'b0;
    beat(10'd52, 10'd5, 1'b1, 8'h00);
    beat(10'd0, 10'd0, 1'b1, 8'h00);
    check("cancel_ack",  32'(ack_mid), 32'd0);
    check("cancel_sel",  32'(a_sel),   32'd1);
    check("cancel_addr", 32'(a_addr),  32'h4B000);

    // Reset mid-line with non-idle outputs
    beat(10'd30, 10'd5, 1'b0, 8'h00);
    beat(10'd31, 10'd5, 1'b0, 8'h2A);
    beat(10'd32, 10'd5, 1'b0, 8'h00);
    beat(10'd33, 10'd5, 1'b0, 8'h00);
    check("prerst_red", 32'(a_r),  32'hAA);
    check("prerst_hs",  32'(a_hs), 32'd0);
    #2 Reset_n = 1'b0;
    #1;
    check("midrst_red",   32'(a_r),    32'd0);
    check("midrst_green", 32'(a_g),    32'd0);
    check("midrst_blue",  32'(a_b),    32'd0);
    check("midrst_hs",    32'(a_hs),   32'd1);
    check("midrst_blank", 32'(a_bl),   32'd0);
    check("midrst_sel",   32'(a_sel),  32'd0);
    check("midrst_ack",   32'(a_ack),  32'd0);
    check("midrst_addr",  32'(a_addr), 32'd0);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    beat(10'd5, 10'd2, 1'b1, 8'h00);
    check("resume_addr", 32'(a_addr), 32'd1285);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
